// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// master drives bytes, slave accepts them.
interface imem_boot_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: framed byte stream in,
// 32-bit LE words out, core held in reset until verified.
module imem_boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_boot_loader_if.slave strm,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        hs;
  logic [15:0] len_in;

  assign hs     = strm.in_valid && strm.in_ready;
  assign len_in = {strm.in_data, count_q[7:0]};
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // next state; write address/data latched on the 4th byte
  // so they are valid during WRITE and hold afterwards
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    sum_d      = sum_q;
    word_d     = word_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          word_idx_d = '0;
          byte_idx_d = '0;
          sum_d      = '0;
          word_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          count_d[7:0] = strm.in_data;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          count_d[15:8] = strm.in_data;
          if (32'(len_in) > 32'(DEPTH))
            state_d = S_ERR;
          else if (len_in == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          word_d[8*byte_idx_q +: 8] = strm.in_data;
          sum_d      = sum_q + strm.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
            waddr_d = ADDR_W'(word_idx_q) << 2;
            wdata_d = {strm.in_data, word_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == count_q)
          state_d = S_CHECK;
        else
          state_d = S_DATA;
      end
      S_CHECK: begin
        if (hs)
          state_d = (strm.in_data == sum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    we            = 1'b0;
    strm.in_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    cpu_rst_n     = 1'b0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: begin
        strm.in_ready = 1'b1;
        busy          = 1'b1;
      end
      S_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: scoreboard of expected
// writes, byte source with optional valid gaps.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy, done, err, cpu_rst_n;

  imem_boot_loader_if bif ();

  imem_boot_loader #(
    .DEPTH (1024),
    .ADDR_W(32)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start),
    .strm     (bif.slave),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          nwr    = 0;
  logic [63:0] sb[$];
  logic [7:0]  fq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic mon();
    logic [63:0] e;
    if (we) begin
      nwr++;
      chk("wr_in_ready", 64'(bif.in_ready), 0);
      chk("wr_align", 64'(waddr[1:0]), 0);
      if (sb.size() == 0) begin
        chk("wr_unexpected", 64'(we), 0);
      end else begin
        e = sb.pop_front();
        chk("waddr", 64'(waddr), 64'(e[63:32]));
        chk("wdata", 64'(wdata), 64'(e[31:0]));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic send(input logic [7:0] b,
                      input bit gap);
    int t;
    if (gap) begin
      bif.in_valid = 1'b0;
      step();
    end
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    t = 0;
    while (!bif.in_ready && t < 64) begin
      step();
      t++;
    end
    if (!bif.in_ready)
      chk("hs_timeout", 64'(bif.in_ready), 1);
    step();
    bif.in_valid = 1'b0;
  endtask

  task automatic send_all(input bit gap);
    foreach (fq[i]) send(fq[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"},   64'(we), 0);
    chk({tag, "_addr"}, 64'(waddr), 0);
    chk({tag, "_data"}, 64'(wdata), 0);
    chk({tag, "_rdy"},  64'(bif.in_ready), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"},  64'(err), 0);
    chk({tag, "_cpu"},  64'(cpu_rst_n), 0);
  endtask

  task automatic push_case1();
    sb.push_back({32'h0, 32'h00100093});
    sb.push_back({32'h4, 32'h00200113});
  endtask

  task automatic fill_case1(input logic [7:0] cs);
    fq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
           8'h13, 8'h01, 8'h20, 8'h00};
    fq.push_back(cs);
  endtask

  task automatic end_ok(input string tag, input int w0,
                        input int nexp);
    chk({tag, "_done"}, 64'(done), 1);
    chk({tag, "_cpu"},  64'(cpu_rst_n), 1);
    chk({tag, "_err"},  64'(err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_nwr"},  64'(nwr - w0), 64'(nexp));
    chk({tag, "_sb"},   64'(sb.size()), 0);
  endtask

  initial begin
    int w0;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    step();
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    step();
    chk("idle_rdy", 64'(bif.in_ready), 0);

    // 1: two-word image
    w0 = nwr;
    push_case1();
    pulse_start();
    chk("c1_busy", 64'(busy), 1);
    fill_case1(8'hD7);
    send_all(1'b0);
    end_ok("c1", w0, 2);

    // 2a: empty image, checksum 0
    w0 = nwr;
    pulse_start();
    chk("c2a_cpu_drop", 64'(cpu_rst_n), 0);
    fq = '{8'h00, 8'h00, 8'h00};
    send_all(1'b0);
    end_ok("c2a", w0, 0);

    // 2b: empty image, bad checksum
    w0 = nwr;
    pulse_start();
    fq = '{8'h00, 8'h00, 8'h05};
    send_all(1'b0);
    chk("c2b_err", 64'(err), 1);
    chk("c2b_done", 64'(done), 0);
    chk("c2b_cpu", 64'(cpu_rst_n), 0);
    chk("c2b_nwr", 64'(nwr - w0), 0);

    // 3: count = DEPTH+1
    w0 = nwr;
    pulse_start();
    fq = '{8'h01, 8'h04};
    send_all(1'b0);
    chk("c3_err", 64'(err), 1);
    chk("c3_rdy", 64'(bif.in_ready), 0);
    chk("c3_busy", 64'(busy), 0);
    step();
    chk("c3_nwr", 64'(nwr - w0), 0);

    // 4: bad checksum after words written
    w0 = nwr;
    push_case1();
    pulse_start();
    fill_case1(8'hD6);
    send_all(1'b0);
    chk("c4_err", 64'(err), 1);
    chk("c4_done", 64'(done), 0);
    chk("c4_cpu", 64'(cpu_rst_n), 0);
    chk("c4_nwr", 64'(nwr - w0), 2);
    chk("c4_sb", 64'(sb.size()), 0);

    // 5: valid toggling
    w0 = nwr;
    push_case1();
    pulse_start();
    fill_case1(8'hD7);
    send_all(1'b1);
    end_ok("c5", w0, 2);

    // 6a: start pulse mid-load is ignored
    w0 = nwr;
    push_case1();
    pulse_start();
    fq = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_all(1'b0);
    pulse_start();
    fq = '{8'h10, 8'h00, 8'h13, 8'h01,
           8'h20, 8'h00, 8'hD7};
    send_all(1'b0);
    end_ok("c6a", w0, 2);

    // 6b: async reset after 5th byte
    pulse_start();
    fq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10};
    send_all(1'b0);
    chk("c6b_busy", 64'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("c6b");
    step();
    step();
    rst_n = 1'b1;
    step();

    // 6c: reload from scratch after abort
    w0 = nwr;
    push_case1();
    pulse_start();
    fill_case1(8'hD7);
    send_all(1'b0);
    end_ok("c6c", w0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
